// File: rtl/apb_pkg.sv
// Shared types and width helpers for the parametrised APB register-file slave.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } apb_state_e;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  function automatic int unsigned idx_w(input int unsigned addr_w);
    return addr_w - 2;
  endfunction

  // The counter is loaded with WAIT_STATES-1, so it never needs to hold WAIT_STATES itself.
  function automatic int unsigned cnt_w(input int unsigned wait_states);
    return (wait_states <= 2) ? 1 : $clog2(wait_states);
  endfunction

  function automatic int unsigned strb_w(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/apb_byte_reg.sv
// One DATA_W-wide register with independent per-byte write enables; clears on reset.
module apb_byte_reg
  import apb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_W/BYTE_W-1:0] be_i,
  input  logic [DATA_W-1:0]        d_i,
  output logic [DATA_W-1:0]        q_o
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      for (int b = 0; b < DATA_W / BYTE_W; b++) begin
        if (be_i[b]) data_q[b*BYTE_W +: BYTE_W] <= d_i[b*BYTE_W +: BYTE_W];
      end
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/apb_regfile_slave.sv
// APB slave register file: RW byte-strobed registers, RO status slots, wait states and PSLVERR.
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter int                     ADDR_W      = 8,
  parameter int                     DATA_W      = 32,
  parameter int                     NUM_REGS    = 8,
  parameter int                     WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0]    RO_MASK     = '0
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic [DATA_W-1:0]            PWDATA,
  input  logic [DATA_W/BYTE_W-1:0]     PSTRB,
  input  logic                         PWRITE,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status_i,
  output logic [NUM_REGS*DATA_W-1:0]   reg_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int unsigned IDX_W    = idx_w(ADDR_W);
  localparam int unsigned CNT_W    = cnt_w(WAIT_STATES);
  localparam int unsigned STRB_W   = strb_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  apb_state_e                        state_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic [DATA_W-1:0]                 prdata_q;
  logic                              pready_q;
  logic                              pslverr_q;
  logic [NUM_REGS-1:0]               wr_pulse_q;

  logic [IDX_W-1:0]                  idx;
  logic [NUM_REGS-1:0]               sel;
  logic                              in_range;
  logic                              is_ro;
  logic                              access;
  logic                              acc_err;
  logic                              do_write;
  logic [NUM_REGS-1:0]               wr_pulse_d;
  logic [DATA_W-1:0]                 rd_data;
  logic [NUM_REGS-1:0][DATA_W-1:0]   rw_q;
  logic                              unused_addr_lsbs;

  assign idx              = PADDR[ADDR_W-1:2];
  assign unused_addr_lsbs = ^PADDR[1:0];

  // One-hot decode; an all-zero result means the index is past the last register.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sel[i] = (idx == IDX_W'(i));
    end
  end

  assign in_range = |sel;
  assign is_ro    = |(sel & RO_MASK);

  assign access = ((state_q == IDLE) && PSEL && PENABLE && (WAIT_STATES == 0)) ||
                  ((state_q == WAIT) && PSEL && (cnt_q == '0));

  assign acc_err    = !in_range || (PWRITE && is_ro);
  assign do_write   = access && PWRITE && in_range && !is_ro;
  assign wr_pulse_d = (PWRITE && in_range && !is_ro && (|PSTRB)) ? sel : '0;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel[i]) rd_data = RO_MASK[i] ? hw_status_i[i*DATA_W +: DATA_W] : rw_q[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (RO_MASK[g]) begin : g_ro
      assign rw_q[g] = '0;
    end else begin : g_rw
      logic [STRB_W-1:0] be;
      assign be = (do_write && sel[g]) ? PSTRB : '0;
      apb_byte_reg #(.DATA_W(DATA_W)) u_reg (
        .clk_i (PCLK),
        .rst_i (PRESET),
        .be_i  (be),
        .d_i   (PWDATA),
        .q_o   (rw_q[g])
      );
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (access) begin
        pready_q   <= 1'b1;
        pslverr_q  <= acc_err;
        prdata_q   <= PWRITE ? '0 : rd_data;
        wr_pulse_q <= wr_pulse_d;
        state_q    <= DONE;
      end else begin
        case (state_q)
          IDLE: begin
            if (PSEL && PENABLE) begin
              cnt_q   <= CNT_LOAD;
              state_q <= WAIT;
            end
          end
          WAIT: begin
            // Master dropped PSEL mid-transfer: abandon it without touching any state.
            if (!PSEL) state_q <= IDLE;
            else       cnt_q   <= cnt_q - 1'b1;
          end
          DONE: begin
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            state_q   <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign PRDATA     = prdata_q;
  assign PREADY     = pready_q;
  assign PSLVERR    = pslverr_q;
  assign wr_pulse_o = wr_pulse_q;
  assign reg_o      = rw_q;

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
- Parametrised APB slave register file; the next generation of the team's 4-register APB slave.
- Adds configurable register count and width, byte strobes (PSTRB), and programmable wait states.
- Adds read-only status registers fed from hardware, and PSLVERR on illegal accesses.
- Sits on the APB bus behind the APB master/decoder; exposes register contents and write pulses to peripheral logic.

Parameters:
- ADDR_W, 8, PADDR width; word index = PADDR[ADDR_W-1:2].
- DATA_W, 32, register/bus width; must be a multiple of 8.
- NUM_REGS, 8, number of registers; must be <= 2^(ADDR_W-2).
- WAIT_STATES, 0, extra access-phase cycles with PREADY=0 beyond the base one; range 0..15.
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes reg i read-only, reading from hw_status_i.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous active-high reset.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  write byte strobes.
- PWRITE  in  1  1=write, 0=read.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PRDATA  out  DATA_W  read data, registered.
- PREADY  out  1  transfer complete, registered.
- PSLVERR  out  1  transfer error, valid only with PREADY.
- hw_status_i  in  NUM_REGS*DATA_W  status values for read-only regs; slice i = reg i.
- reg_o  out  NUM_REGS*DATA_W  current RW register contents; RO slices driven 0.
- wr_pulse_o  out  NUM_REGS  one-cycle pulse per successful write to reg i.

Behaviour:
- Reset (async, PRESET=1): all RW regs 0; PRDATA 0; PREADY 0; PSLVERR 0; wr_pulse_o 0; FSM=IDLE; wait counter 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE: on PSEL&&PENABLE:
  - WAIT_STATES==0: perform access at this edge, go to DONE.
  - Otherwise: load cnt<=WAIT_STATES-1, go to WAIT.
- WAIT:
  - PSEL==0 (aborted transfer): return to IDLE with no access and no PREADY.
  - cnt==0: perform access, go to DONE.
  - Otherwise: cnt decrements.
- Perform access (single edge): PREADY<=1; PSLVERR and PRDATA set per rules below; write committed.
- DONE: PREADY<=0, PSLVERR<=0, wr_pulse_o<=0; go to IDLE unconditionally.
- Latency: PREADY is high in the (WAIT_STATES+2)th access-phase cycle; it is high for exactly one cycle per transfer.
- Back-to-back transfers: a setup phase coinciding with DONE is accepted; the next access is detected in IDLE.
- Index rules:
  - idx = PADDR[ADDR_W-1:2]; PADDR[1:0] is ignored (word-aligned access only).
  - idx >= NUM_REGS: PSLVERR=1, no write, PRDATA=0.
- Write, RW reg:
  - For each byte b with PSTRB[b]=1, reg[idx][8b+7:8b] <= PWDATA byte b; unstrobed bytes hold.
  - wr_pulse_o[idx]=1 for that one cycle, only if PSTRB != 0.
  - PSTRB==0: no change, no pulse, no error.
  - PRDATA<=0 on writes.
- Write, RO reg (RO_MASK[idx]=1): PSLVERR=1, no state change, no pulse.
- Read:
  - RW reg: PRDATA <= reg[idx].
  - RO reg: PRDATA <= hw_status_i slice idx, sampled at the access edge.
  - PSLVERR=0.
- PRDATA holds its value after DONE until the next access.
- reg_o is continuously driven from the RW registers; a write is visible on reg_o the cycle after the access edge, coincident with PREADY.
- Reset mid-transfer: immediate return to reset values; no partial write.
- Illegal/impossible PSEL/PENABLE combinations outside the APB protocol: no access performed; only the PSEL&&PENABLE detection in IDLE/WAIT matters.

Decomposition:
- Package apb_pkg:
  - enum apb_state_e {IDLE, WAIT, DONE}.
  - localparam function clog2-based widths for idx and the wait counter.
  - Typedef for the strobe vector width.
- One natural sub-module: apb_byte_reg (a single DATA_W register with per-byte write enables and reset to 0), instantiated NUM_REGS times via generate; RO slots are not instantiated.

Test Plan:
- WAIT_STATES=0, write 0xDEADBEEF with PSTRB=0xF to PADDR 0x04 -> PREADY high in 2nd access cycle; PSLVERR=0; wr_pulse_o=0x02 for one cycle; reg_o slice1=0xDEADBEEF. Read 0x04 -> PRDATA=0xDEADBEEF.
- Strobe merge: reg2=0x11223344, write 0xAABBCCDD with PSTRB=0b0101 -> reg2=0x11BB33DD; PSTRB=0 write -> unchanged, no pulse, PSLVERR=0.
- RO_MASK=0x80, hw_status_i slice7=0x0000CAFE: read PADDR 0x1C -> PRDATA=0x0000CAFE, PSLVERR=0. Write 0x1C -> PSLVERR=1 with PREADY, no wr_pulse.
- Out of range (NUM_REGS=8): read and write to PADDR 0x20 -> PSLVERR=1, PRDATA=0, no register changes.
- WAIT_STATES=3: PREADY low for 4 access cycles, high in the 5th. Deassert PSEL in the 2nd wait cycle -> FSM returns to IDLE, no write, PREADY never rises.
- Assert PRESET mid-WAIT after a prior write of 0x5 -> all regs, PRDATA, PREADY, PSLVERR = 0 immediately; the next transfer completes normally.
